// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared definitions for the EX-stage hazard controller: forwarding select
// encodings, the scoreboard slot layout and the slot match helper.
package ex_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam int unsigned SB_AW = 5;

    typedef struct packed {
        logic             valid;
        logic             reg_write;
        logic             is_load;
        logic [SB_AW-1:0] wreg;
    } sb_slot_t;

    localparam int unsigned SB_SLOT_W = $bits(sb_slot_t);
    localparam sb_slot_t    SB_BUBBLE = '0;

    // $0 is hard-wired, so a slot never "writes" it.
    function automatic logic slot_writes(input sb_slot_t s, input logic [SB_AW-1:0] r);
        return s.valid & s.reg_write & (s.wreg == r) & (r != '0);
    endfunction

endpackage

// File: rtl/ex_hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous reset and a freeze input.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             hold,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && !hold && !(&count_q)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: EX/MEM/WB destination scoreboard,
// registered EX forwarding selects, load-use stall and taken-branch flush.
module ex_hazard_ctrl
    import ex_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_reg_write,
    input  logic              id_is_load,
    input  logic [REG_AW-1:0] id_write_reg,
    input  logic              ex_branch_taken,
    output logic              stall,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    sb_slot_t   ex_q,  mem_q,  wb_q;
    sb_slot_t   ex_d;
    logic [1:0] fwd_a_q, fwd_b_q;
    logic [1:0] fwd_a_d, fwd_b_d;
    logic       load_use;
    logic       flush;
    logic       issue;

    function automatic logic [1:0] fwd_sel(input logic used, input logic [SB_AW-1:0] r,
                                           input sb_slot_t ex_s, input sb_slot_t mem_s);
        if (!used)                      return FWD_REG;
        else if (slot_writes(ex_s, r))  return FWD_MEM;
        else if (slot_writes(mem_s, r)) return FWD_WB;
        else                            return FWD_REG;
    endfunction

    always_comb begin
        load_use = id_valid &
                   ((id_uses_rs & ex_q.is_load & slot_writes(ex_q, id_rs)) |
                    (id_uses_rt & ex_q.is_load & slot_writes(ex_q, id_rt)));
        // Outputs are forced low while reset is held so no stale request leaks out.
        flush = ex_branch_taken & ~hold & ~reset;
        stall = load_use & ~ex_branch_taken & ~hold & ~reset;
        issue = id_valid & ~stall & ~ex_branch_taken;

        ex_d    = SB_BUBBLE;
        fwd_a_d = FWD_REG;
        fwd_b_d = FWD_REG;
        if (issue) begin
            ex_d.valid     = 1'b1;
            ex_d.reg_write = id_reg_write;
            ex_d.is_load   = id_is_load;
            ex_d.wreg      = id_write_reg;
            fwd_a_d        = fwd_sel(id_uses_rs, id_rs, ex_q, mem_q);
            fwd_b_d        = fwd_sel(id_uses_rt, id_rt, ex_q, mem_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q    <= SB_BUBBLE;
            mem_q   <= SB_BUBBLE;
            wb_q    <= SB_BUBBLE;
            fwd_a_q <= FWD_REG;
            fwd_b_q <= FWD_REG;
        end else if (!hold) begin
            wb_q    <= mem_q;
            mem_q   <= ex_q;
            ex_q    <= ex_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign flush_if_id = flush;
    assign flush_id_ex = flush;
    assign fwd_a       = fwd_a_q;
    assign fwd_b       = fwd_b_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall),
        .hold  (hold),
        .count (stall_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush),
        .hold  (hold),
        .count (flush_count)
    );

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl; counters narrowed so saturation is reachable quickly.
module tb_ex_hazard_ctrl;

    localparam int unsigned AW = 5;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset, hold, id_valid, id_uses_rs, id_uses_rt;
    logic          id_reg_write, id_is_load, ex_branch_taken;
    logic [AW-1:0] id_rs, id_rt, id_write_reg;
    logic          stall, flush_if_id, flush_id_ex;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_count, flush_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .hold(hold), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_write_reg(id_write_reg),
        .ex_branch_taken(ex_branch_taken), .stall(stall), .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    task automatic next;
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [AW-1:0] rs, input logic urs,
                          input logic [AW-1:0] rt, input logic urt,
                          input logic rw, input logic ld, input logic [AW-1:0] wr);
        id_valid = v; id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
        id_reg_write = rw; id_is_load = ld; id_write_reg = wr;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) begin
            next;
            set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; hold = 1'b0; ex_branch_taken = 1'b1;
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd1);
        next; next;
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", stall); end
        checks++; if (flush_if_id !== 1'b0 || flush_id_ex !== 1'b0) begin errors++; $display("FAIL reset_flush got %0b%0b want 00", flush_if_id, flush_id_ex); end
        checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin errors++; $display("FAIL reset_fwd got %0b/%0b want 00/00", fwd_a, fwd_b); end
        checks++; if (stall_count !== 4'd0 || flush_count !== 4'd0) begin errors++; $display("FAIL reset_counts got %0d/%0d want 0/0", stall_count, flush_count); end
        next;
        reset = 1'b0; ex_branch_taken = 1'b0;
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        @(negedge clk);
        nops(3);
    endtask

    task automatic test_fwd_ex;
        next; set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3);   // add $3,$1,$2
        @(negedge clk);
        next; set_id(1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0);   // uses $3 as rs
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fwd_ex_stall got %0b want 0", stall); end
        next; set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        @(negedge clk);
        checks++; if (fwd_a !== 2'b01) begin errors++; $display("FAIL fwd_ex_a got %0b want 01", fwd_a); end
        checks++; if (fwd_b !== 2'b00) begin errors++; $display("FAIL fwd_ex_b got %0b want 00", fwd_b); end
        nops(3);
    endtask

    task automatic test_fwd_wb;
        next; set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3);
        @(negedge clk);
        next; set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        @(negedge clk);
        next; set_id(1'b1, 5'd6, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 5'd7);   // sub $7,$6,$3
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fwd_wb_stall got %0b want 0", stall); end
        next; set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        @(negedge clk);
        checks++; if (fwd_b !== 2'b10) begin errors++; $display("FAIL fwd_wb_b got %0b want 10", fwd_b); end
        checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL fwd_wb_a got %0b want 00", fwd_a); end
        nops(3);
    endtask

    task automatic test_load_use;
        next; set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 5'd4);   // lw $4
        @(negedge clk);
        next; set_id(1'b1, 5'd4, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 5'd8);   // add $8,$4,$7
        @(negedge clk);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %0b want 1", stall); end
        checks++; if (flush_id_ex !== 1'b0) begin errors++; $display("FAIL lu_flush got %0b want 0", flush_id_ex); end
        next;
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_once got %0b want 0", stall); end
        checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL lu_bubble_fwd got %0b want 00", fwd_a); end
        next; set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        @(negedge clk);
        checks++; if (fwd_a !== 2'b10 || fwd_b !== 2'b00) begin errors++; $display("FAIL lu_fwd got %0b/%0b want 10/00", fwd_a, fwd_b); end
        checks++; if (stall_count !== 4'd1) begin errors++; $display("FAIL lu_count got %0d want 1", stall_count); end
        nops(3);
    endtask

    task automatic test_branch;
        next; set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 5'd4);
        @(negedge clk);
        next; set_id(1'b1, 5'd4, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 5'd8);
        ex_branch_taken = 1'b1;
        @(negedge clk);
        checks++; if (flush_if_id !== 1'b1 || flush_id_ex !== 1'b1) begin errors++; $display("FAIL br_flush got %0b%0b want 11", flush_if_id, flush_id_ex); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL br_stall got %0b want 0", stall); end
        next; ex_branch_taken = 1'b0;
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        @(negedge clk);
        checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL br_bubble_fwd got %0b want 00", fwd_a); end
        checks++; if (flush_count !== 4'd1 || stall_count !== 4'd1) begin errors++; $display("FAIL br_counts got %0d/%0d want 1/1", flush_count, stall_count); end
        nops(3);
    endtask

    task automatic test_zero_reg;
        next; set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0);   // add $0
        @(negedge clk);
        next; set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_add_stall got %0b want 0", stall); end
        next; set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0);   // lw $0
        @(negedge clk);
        checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin errors++; $display("FAIL zero_fwd got %0b/%0b want 00/00", fwd_a, fwd_b); end
        next; set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_lw_stall got %0b want 0", stall); end
        nops(3);
    endtask

    task automatic test_hold;
        next; set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd3);   // add $3
        @(negedge clk);
        next; set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 5'd4);   // lw $4,($3)
        @(negedge clk);
        next; set_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd9);
        hold = 1'b1; ex_branch_taken = 1'b1;
        @(negedge clk);
        checks++; if (stall !== 1'b0 || flush_if_id !== 1'b0) begin errors++; $display("FAIL hold_outs got %0b/%0b want 0/0", stall, flush_if_id); end
        checks++; if (fwd_a !== 2'b01) begin errors++; $display("FAIL hold_fwd0 got %0b want 01", fwd_a); end
        for (int i = 0; i < 2; i++) begin
            next;
            @(negedge clk);
            checks++; if (fwd_a !== 2'b01 || stall !== 1'b0) begin errors++; $display("FAIL hold_frozen got fwd %0b stall %0b want 01/0", fwd_a, stall); end
            checks++; if (stall_count !== 4'd1 || flush_count !== 4'd1) begin errors++; $display("FAIL hold_counts got %0d/%0d want 1/1", stall_count, flush_count); end
        end
        next; hold = 1'b0; ex_branch_taken = 1'b0;
        @(negedge clk);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hold_release_stall got %0b want 1", stall); end
        next;
        @(negedge clk);
        checks++; if (stall !== 1'b0 || fwd_a !== 2'b00) begin errors++; $display("FAIL hold_bubble got stall %0b fwd %0b want 0/00", stall, fwd_a); end
        next; set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        @(negedge clk);
        checks++; if (fwd_a !== 2'b10 || stall_count !== 4'd2) begin errors++; $display("FAIL hold_after got fwd %0b cnt %0d want 10/2", fwd_a, stall_count); end
        nops(3);
    endtask

    task automatic test_saturate;
        int seen;
        seen = 0;
        for (int i = 0; i < 42; i++) begin
            next; set_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 5'd4);  // lw $4,($4)
            @(negedge clk);
            if (stall === 1'b1) seen++;
        end
        next; set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        @(negedge clk);
        checks++; if (seen != 21) begin errors++; $display("FAIL sat_stalls_seen got %0d want 21", seen); end
        checks++; if (stall_count !== 4'hF) begin errors++; $display("FAIL sat_count got %0h want f", stall_count); end
        nops(3);
    endtask

    task automatic test_mid_reset;
        next; set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 5'd4);
        @(negedge clk);
        next; reset = 1'b1; ex_branch_taken = 1'b1;
        set_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd5);
        @(negedge clk);
        checks++; if (stall !== 1'b0 || flush_id_ex !== 1'b0) begin errors++; $display("FAIL mrst_outs got %0b/%0b want 0/0", stall, flush_id_ex); end
        next; reset = 1'b0; ex_branch_taken = 1'b0;
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mrst_dropped got %0b want 0", stall); end
        checks++; if (stall_count !== 4'd0 || flush_count !== 4'd0 || fwd_a !== 2'b00) begin errors++; $display("FAIL mrst_state got %0d/%0d/%0b want 0/0/00", stall_count, flush_count, fwd_a); end
        nops(2);
    endtask

    initial begin
        test_reset;
        test_fwd_ex;
        test_fwd_wb;
        test_load_use;
        test_branch;
        test_zero_reg;
        test_hold;
        test_saturate;
        test_mid_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
